// File: rtl/axis_pattern_checker.sv
// AXI4-Stream sink that checks an incrementing-counter stream from its upstream source.
// It drives programmable back-pressure on tready, counts accepted and mismatching beats,
// and captures the first mismatch.
module axis_pattern_checker #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int unsigned READY_ON   = 20,
    parameter int unsigned READY_OFF  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  init_axi_txn,
    input  logic [1:0]            ready_mode,
    input  logic                  clear_stats,
    output logic [31:0]           beat_count,
    output logic [15:0]           error_count,
    output logic                  error_sticky,
    output logic [DATA_WIDTH-1:0] first_bad_data,
    output logic [DATA_WIDTH-1:0] first_exp_data,
    output logic                  synced
);

    localparam int unsigned PERIOD = READY_ON + READY_OFF;
    localparam int unsigned DUTY_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    typedef enum logic {
        ST_SYNC,
        ST_CHECK
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;
    logic [31:0]           beat_q, beat_d;
    logic [15:0]           err_q, err_d;
    logic                  sticky_q, sticky_d;
    logic [DATA_WIDTH-1:0] bad_q, bad_d;
    logic [DATA_WIDTH-1:0] expc_q, expc_d;
    logic                  synced_q;
    logic                  tready_q, tready_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic                  lfsr_fb;
    logic [DUTY_W-1:0]     duty_q, duty_d, duty_cur;
    logic [1:0]            mode_q;
    logic                  accept;

    assign accept  = s_axis_tvalid & tready_q;
    // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0.
    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    // Next tready value; duty counter restarts in the ON phase whenever mode 2 is entered.
    always_comb begin
        tready_d = 1'b0;
        lfsr_d   = lfsr_q;
        duty_d   = duty_q;
        duty_cur = (mode_q == 2'd2) ? duty_q : '0;
        case (ready_mode)
            2'd0: tready_d = 1'b1;
            2'd1: begin
                tready_d = lfsr_q[0];
                lfsr_d   = {lfsr_fb, lfsr_q[15:1]};
            end
            2'd2: begin
                tready_d = (duty_cur < DUTY_W'(READY_ON));
                duty_d   = (duty_cur == DUTY_W'(PERIOD - 1)) ? '0 : duty_cur + DUTY_W'(1);
            end
            default: tready_d = 1'b0;
        endcase
    end

    // Checker next-state and statistics; a beat coincident with init acts as the new seed.
    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        beat_d   = beat_q;
        err_d    = err_q;
        sticky_d = sticky_q;
        bad_d    = bad_q;
        expc_d   = expc_q;

        if (init_axi_txn) begin
            state_d = ST_SYNC;
        end

        if (accept) begin
            beat_d = (beat_q == 32'hFFFF_FFFF) ? beat_q : beat_q + 32'd1;
            if (init_axi_txn || state_q == ST_SYNC) begin
                exp_d   = s_axis_tdata + DATA_WIDTH'(1);
                state_d = ST_CHECK;
            end else if (s_axis_tdata == exp_q) begin
                exp_d = exp_q + DATA_WIDTH'(1);
            end else begin
                err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
                if (!sticky_q) begin
                    bad_d    = s_axis_tdata;
                    expc_d   = exp_q;
                    sticky_d = 1'b1;
                end
                exp_d = s_axis_tdata + DATA_WIDTH'(1);
            end
        end

        if (clear_stats) begin
            beat_d   = '0;
            err_d    = '0;
            sticky_d = 1'b0;
            bad_d    = '0;
            expc_d   = '0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_SYNC;
            exp_q    <= '0;
            beat_q   <= '0;
            err_q    <= '0;
            sticky_q <= 1'b0;
            bad_q    <= '0;
            expc_q   <= '0;
            synced_q <= 1'b0;
            tready_q <= 1'b0;
            lfsr_q   <= LFSR_SEED;
            duty_q   <= '0;
            mode_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            bad_q    <= bad_d;
            expc_q   <= expc_d;
            synced_q <= (state_d == ST_CHECK);
            tready_q <= tready_d;
            lfsr_q   <= lfsr_d;
            duty_q   <= duty_d;
            mode_q   <= ready_mode;
        end
    end

    assign s_axis_tready  = tready_q;
    assign beat_count     = beat_q;
    assign error_count    = err_q;
    assign error_sticky   = sticky_q;
    assign first_bad_data = bad_q;
    assign first_exp_data = expc_q;
    assign synced         = synced_q;

endmodule

// File: tb/tb_axis_pattern_checker.sv
// Directed bench for axis_pattern_checker: drives at negedge, samples at negedge.
module tb_axis_pattern_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        init_axi_txn;
    logic [1:0]  ready_mode;
    logic        clear_stats;
    logic [31:0] beat_count;
    logic [15:0] error_count;
    logic        error_sticky;
    logic [31:0] first_bad_data;
    logic [31:0] first_exp_data;
    logic        synced;

    int errors = 0;
    int checks = 0;
    int stalls = 0;
    logic [15:0] lfsr_model = 16'hACE1;

    always #5 clk = ~clk;

    axis_pattern_checker #(
        .DATA_WIDTH(32),
        .LFSR_SEED (16'hACE1),
        .READY_ON  (20),
        .READY_OFF (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .init_axi_txn  (init_axi_txn),
        .ready_mode    (ready_mode),
        .clear_stats   (clear_stats),
        .beat_count    (beat_count),
        .error_count   (error_count),
        .error_sticky  (error_sticky),
        .first_bad_data(first_bad_data),
        .first_exp_data(first_exp_data),
        .synced        (synced)
    );

    // Holds one beat until accepted; starts and ends just after a negedge.
    task automatic drive_beat(input logic [31:0] d);
        int waits = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        while (s_axis_tready !== 1'b1 && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        checks++;
        if (waits >= 200) begin
            errors++;
            $display("FAIL beat_accept data=%h not accepted within %0d cycles", d, waits);
        end else begin
            @(negedge clk);
            stalls += waits;
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear_init();
        s_axis_tvalid = 1'b0;
        clear_stats   = 1'b1;
        init_axi_txn  = 1'b1;
        @(negedge clk);
        clear_stats   = 1'b0;
        init_axi_txn  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
        init_axi_txn = 1'b0; ready_mode = 2'd0; clear_stats = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_axis_tready, error_sticky, synced} !== 3'b000 || beat_count !== 32'd0 ||
            error_count !== 16'd0 || first_bad_data !== 32'd0 || first_exp_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b stk=%b syn=%b beats=%0d errs=%0d bad=%h exp=%h want all zero",
                     s_axis_tready, error_sticky, synced, beat_count, error_count,
                     first_bad_data, first_exp_data);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b want 1", s_axis_tready);
        end
    endtask

    task automatic test_contiguous();
        stalls = 0;
        for (int i = 0; i < 100; i++) drive_beat(32'(i));
        idle(1);
        checks++;
        if (stalls !== 0) begin
            errors++;
            $display("FAIL mode0_stalls got %0d want 0", stalls);
        end
        checks++;
        if (beat_count !== 32'd100 || error_count !== 16'd0 || synced !== 1'b1 || error_sticky !== 1'b0) begin
            errors++;
            $display("FAIL contiguous got beats=%0d errs=%0d syn=%b stk=%b want 100 0 1 0",
                     beat_count, error_count, synced, error_sticky);
        end
    endtask

    task automatic test_mismatch();
        logic [31:0] vals [6];
        vals = '{32'd5, 32'd6, 32'd7, 32'd20, 32'd21, 32'd22};
        pulse_clear_init();
        foreach (vals[i]) drive_beat(vals[i]);
        idle(1);
        checks++;
        if (error_count !== 16'd1 || first_bad_data !== 32'd20 || first_exp_data !== 32'd8 ||
            error_sticky !== 1'b1 || beat_count !== 32'd6) begin
            errors++;
            $display("FAIL glitch got errs=%0d bad=%0d exp=%0d stk=%b beats=%0d want 1 20 8 1 6",
                     error_count, first_bad_data, first_exp_data, error_sticky, beat_count);
        end
        drive_beat(32'd100);
        idle(1);
        checks++;
        if (error_count !== 16'd2 || first_bad_data !== 32'd20 || first_exp_data !== 32'd8) begin
            errors++;
            $display("FAIL first_capture_held got errs=%0d bad=%0d exp=%0d want 2 20 8",
                     error_count, first_bad_data, first_exp_data);
        end
    endtask

    task automatic test_wrap();
        pulse_clear_init();
        drive_beat(32'hFFFF_FFFE);
        drive_beat(32'hFFFF_FFFF);
        drive_beat(32'h0000_0000);
        drive_beat(32'h0000_0001);
        idle(1);
        checks++;
        if (error_count !== 16'd0 || beat_count !== 32'd4) begin
            errors++;
            $display("FAIL wrap got errs=%0d beats=%0d want 0 4", error_count, beat_count);
        end
    endtask

    task automatic test_duty();
        int bad = 0;
        logic r_prev;
        logic exp_r;
        logic [31:0] d = 32'd7000;
        ready_mode = 2'd3;
        idle(3);
        checks++;
        if (s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL mode3_ready got %b want 0", s_axis_tready);
        end
        pulse_clear_init();
        ready_mode    = 2'd2;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        r_prev        = s_axis_tready;
        for (int k = 1; k <= 230; k++) begin
            @(negedge clk);
            if (r_prev) d++;
            exp_r = (((k - 1) % 23) < 20);
            if (s_axis_tready !== exp_r) bad++;
            r_prev = s_axis_tready;
            if (k < 230) s_axis_tdata = d;
            else s_axis_tvalid = 1'b0;
        end
        idle(1);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL duty_pattern got %0d wrong cycles want 0", bad);
        end
        checks++;
        if (beat_count !== 32'd200 || error_count !== 16'd0) begin
            errors++;
            $display("FAIL duty_beats got beats=%0d errs=%0d want 200 0", beat_count, error_count);
        end
    endtask

    task automatic test_lfsr();
        int bad = 0;
        int exp_beats = 0;
        logic r_prev;
        logic exp_r;
        logic fb;
        logic [31:0] d = 32'd300;
        ready_mode = 2'd3;
        idle(2);
        pulse_clear_init();
        ready_mode    = 2'd1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        r_prev        = s_axis_tready;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (r_prev) d++;
            exp_r = lfsr_model[0];
            fb = lfsr_model[0] ^ lfsr_model[2] ^ lfsr_model[3] ^ lfsr_model[5];
            lfsr_model = {fb, lfsr_model[15:1]};
            if (s_axis_tready !== exp_r) bad++;
            if (k < 64 && exp_r) exp_beats++;
            r_prev = s_axis_tready;
            if (k < 64) s_axis_tdata = d;
            else begin
                s_axis_tvalid = 1'b0;
                ready_mode    = 2'd3;
            end
        end
        idle(4);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL lfsr_pattern got %0d wrong cycles want 0", bad);
        end
        checks++;
        if (beat_count !== 32'(exp_beats) || error_count !== 16'd0) begin
            errors++;
            $display("FAIL lfsr_beats got beats=%0d errs=%0d want %0d 0", beat_count, error_count, exp_beats);
        end
        ready_mode = 2'd1;
        @(negedge clk);
        checks++;
        if (s_axis_tready !== lfsr_model[0]) begin
            errors++;
            $display("FAIL lfsr_hold got %b want %b", s_axis_tready, lfsr_model[0]);
        end
        ready_mode = 2'd0;
        idle(2);
    endtask

    task automatic test_init_resync();
        pulse_clear_init();
        for (int i = 0; i < 10; i++) drive_beat(32'(i));
        init_axi_txn = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'd500;
        @(negedge clk);
        init_axi_txn = 1'b0;
        for (int i = 501; i <= 505; i++) drive_beat(32'(i));
        idle(1);
        checks++;
        if (error_count !== 16'd0 || beat_count !== 32'd16 || error_sticky !== 1'b0) begin
            errors++;
            $display("FAIL init_resync got errs=%0d beats=%0d stk=%b want 0 16 0",
                     error_count, beat_count, error_sticky);
        end
    endtask

    task automatic test_reset_mid();
        drive_beat(32'd506);
        drive_beat(32'd999);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'd12345;
        rst = 1'b1;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        checks++;
        if ({s_axis_tready, error_sticky, synced} !== 3'b000 || beat_count !== 32'd0 ||
            error_count !== 16'd0 || first_bad_data !== 32'd0 || first_exp_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid got rdy=%b stk=%b syn=%b beats=%0d errs=%0d bad=%h exp=%h want all zero",
                     s_axis_tready, error_sticky, synced, beat_count, error_count,
                     first_bad_data, first_exp_data);
        end
        rst = 1'b0;
        @(negedge clk);
        drive_beat(32'd1000);
        drive_beat(32'd1001);
        idle(1);
        checks++;
        if (error_count !== 16'd0 || beat_count !== 32'd2 || synced !== 1'b1) begin
            errors++;
            $display("FAIL reseed_after_reset got errs=%0d beats=%0d syn=%b want 0 2 1",
                     error_count, beat_count, synced);
        end
    endtask

    task automatic test_clear_coincident();
        drive_beat(32'd1002);
        clear_stats = 1'b1;
        drive_beat(32'd7777);
        clear_stats = 1'b0;
        idle(1);
        checks++;
        if (beat_count !== 32'd0 || error_count !== 16'd0 || error_sticky !== 1'b0) begin
            errors++;
            $display("FAIL clear_wins got beats=%0d errs=%0d stk=%b want 0 0 0",
                     beat_count, error_count, error_sticky);
        end
        drive_beat(32'd7778);
        idle(1);
        checks++;
        if (beat_count !== 32'd1 || error_count !== 16'd0 || synced !== 1'b1) begin
            errors++;
            $display("FAIL after_clear got beats=%0d errs=%0d syn=%b want 1 0 1",
                     beat_count, error_count, synced);
        end
    endtask

    initial begin
        test_reset();
        test_contiguous();
        test_mismatch();
        test_wrap();
        test_duty();
        test_lfsr();
        test_init_resync();
        test_reset_mid();
        test_clear_coincident();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_pattern_checker.md
Name: axis_pattern_checker

Overview:
- AXI4-Stream sink directly downstream of AXI4_Test_Module; consumes its 32-bit incrementing-counter stream.
- Generates programmable back-pressure on tready, checks each accepted beat against an expected +1 sequence, and exposes beat/error counters and the first-mismatch capture.
- Used as the standalone consumer in simulation and as an on-chip link checker ahead of the DMA path.

Parameters:
- DATA_WIDTH, 32, stream data width.
- LFSR_SEED, 16'hACE1, non-zero seed of the 16-bit Fibonacci LFSR (taps 16,14,13,11) used for random ready.
- READY_ON, 20, cycles tready high in duty mode (>=1).
- READY_OFF, 3, cycles tready low in duty mode (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- s_axis_tdata  in  DATA_WIDTH  stream data from upstream.
- s_axis_tvalid  in  1  upstream data valid.
- s_axis_tready  out  1  sink ready, registered.
- init_axi_txn  in  1  upstream transaction-start pulse; resynchronises the checker.
- ready_mode  in  2  0 always ready, 1 LFSR random, 2 duty cycle, 3 never ready.
- clear_stats  in  1  single-cycle pulse; zeroes counters and sticky flags.
- beat_count  out  32  accepted beats, saturating at 32'hFFFF_FFFF.
- error_count  out  16  mismatching beats, saturating at 16'hFFFF.
- error_sticky  out  1  set on the first mismatch, held until clear_stats or rst.
- first_bad_data  out  DATA_WIDTH  data of the first mismatching beat.
- first_exp_data  out  DATA_WIDTH  expected value at the first mismatch.
- synced  out  1  high while in CHECK state.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - s_axis_tready=0, all counters 0, error_sticky=0, first_* = 0, synced=0.
  - LFSR=LFSR_SEED, duty counter=0, state=SYNC, expected=0.
- Handshake:
  - A beat is accepted when s_axis_tvalid & s_axis_tready are both high at a posedge.
  - tready never depends combinationally on tvalid.
  - tdata/tvalid are not checked for stability while tready=0.
- Ready generation, registered; a new mode takes effect on the cycle after the change:
  - mode 0: tready=1 from the first cycle after reset deasserts.
  - mode 1: tready = LFSR[0]. The LFSR advances every cycle in mode 1 only; it holds otherwise.
  - mode 2: tready high for READY_ON cycles, then low for READY_OFF cycles, repeating. The counter restarts at the ON phase whenever mode 2 is entered.
  - mode 3: tready=0.
- State machine:
  - SYNC: the first accepted beat is not checked; expected <= tdata+1; go to CHECK.
  - CHECK: on each accepted beat, compare tdata with expected.
    - Match: expected <= expected+1.
    - Mismatch: error_count++; if error_sticky=0, capture first_bad_data=tdata and first_exp_data=expected, then set error_sticky. expected <= tdata+1, so the checker resyncs and one glitch counts exactly once. Stay in CHECK.
  - init_axi_txn=1 in any state: next state SYNC. A beat accepted in the same cycle is treated as the SYNC seed (not checked, counted in beat_count).
- Arithmetic:
  - expected wraps modulo 2^DATA_WIDTH; 32'hFFFF_FFFF followed by 0 is a match.
  - Counters saturate and do not wrap.
- Every accepted beat increments beat_count, in either state.
- clear_stats: zeroes beat_count, error_count, error_sticky and first_*.
  - If a beat is accepted in the same cycle, clear wins and that beat's increments are dropped.
  - State, expected, LFSR and duty counter are unaffected.
- rst mid-stream: any in-flight beat is dropped, no partial updates; the first beat after reset re-seeds.
- Output latency: counters and flags update on the posedge that accepts the beat and are visible the following cycle.

Test Plan:
- mode 0, source sends 0..99 continuously -> tready=1 every cycle after reset, beat_count=100, error_count=0, synced=1, error_sticky=0.
- mode 0, stream 5,6,7,20,21,22 -> error_count=1, first_bad_data=20, first_exp_data=8, error_sticky=1, no further errors after 20.
- Wrap: stream 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 1 -> error_count=0, beat_count=4.
- mode 2 with READY_ON=20/READY_OFF=3, tvalid held high for 230 cycles -> tready pattern 20 high / 3 low repeating, exactly 200 beats accepted, error_count=0.
- mode 1 -> tready sequence matches the reference LFSR model from seed 16'hACE1 for 64 cycles; accepted data still contiguous, error_count=0.
- Stream 0..9, init_axi_txn with beat 500, then 501..505; separately rst mid-stream and clear_stats coincident with a beat -> after the init pulse no error and beat_count=16; after rst all outputs 0 and the next beat seeds; the coincident beat is not counted.
